// File: rtl/uart_pkg.sv
// Shared definitions for the UART path: parity modes, TX state encoding,
// standard bit timing and the parameter legality rules used at elaboration.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // 100 MHz / 115200 baud, rounded to the nearest whole cycle.
  localparam int CLKS_PER_BIT_115200 = 868;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic bit uart_params_legal(input int data_bits,
                                           input int parity,
                                           input int stop_bits,
                                           input int clks_per_bit);
    bit ok;
    ok = (data_bits >= 5) && (data_bits <= 9);
    ok = ok && (parity == PARITY_NONE || parity == PARITY_ODD || parity == PARITY_EVEN);
    ok = ok && (stop_bits == 1 || stop_bits == 2);
    ok = ok && (clks_per_bit >= 2);
    return ok;
  endfunction

  function automatic bit baud_param_legal(input int clks_per_bit);
    return clks_per_bit >= 2;
  endfunction

  // Zero-extension of narrower payloads does not disturb the XOR reduction.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Producer-to-transmitter valid/ready channel carrying one payload word.
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_in;
    logic                 in_valid;
    logic                 in_ready;

    modport master (
        output data_in,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  data_in,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Free-running bit-period counter with a one-cycle bit_end strobe; shared by
// the UART TX and RX blocks.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
    input  logic clk_100m,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic bit_end
);

    localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    if (!baud_param_legal(CLKS_PER_BIT)) begin : g_bad_params
        $error("uart_baud_gen: CLKS_PER_BIT must be at least 2");
    end

    logic [CNT_W-1:0] cnt_q;

    // NOTE: clocked state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk_100m) begin
        if (rst || restart) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    assign bit_end = enable && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: one-entry holding register in front of a
// start/data/parity/stop framer, with back-to-back frames at full line rate.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PARITY_NONE,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
    input  logic             clk_100m,
    input  logic             rst,
    uart_tx_param_if.slave   up,
    output logic             tx,
    output logic             tx_busy
);

    if (!uart_params_legal(DATA_BITS, PARITY, STOP_BITS, CLKS_PER_BIT)) begin : g_bad_params
        $error("uart_tx_param: illegal DATA_BITS/PARITY/STOP_BITS/CLKS_PER_BIT");
    end

    localparam int               IDX_W      = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_BITS - 1);
    localparam bit               HAS_PARITY = (PARITY != PARITY_NONE);
    localparam bit               TWO_STOP   = (STOP_BITS == 2);

    tx_state_e            state_q, state_d;
    logic                 tx_q, tx_d;
    logic                 busy_q;
    logic                 in_ready_q;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic                 par_q, par_d;
    logic                 load;
    logic                 accept;
    logic                 bit_end;

    assign accept = up.in_valid && in_ready_q;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk_100m (clk_100m),
        .rst      (rst),
        .restart  (load),
        .enable   (state_q != ST_IDLE),
        .bit_end  (bit_end)
    );

    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a latch.
        state_d = state_q;
        tx_d    = tx_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        par_d   = par_q;
        load    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (hold_full_q) load = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    idx_d   = '0;
                    par_d   = parity_bit(9'(shreg_q), PARITY);
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q == LAST_IDX) begin
                        stop_d = 1'b0;
                        if (HAS_PARITY) begin
                            tx_d    = par_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (TWO_STOP && !stop_q) begin
                        stop_d = 1'b1;
                    end else if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Loading from IDLE and chaining from the last stop bit share one path.
        if (load) begin
            shreg_d = hold_q;
            tx_d    = 1'b0;
            state_d = ST_START;
        end

        hold_d      = accept ? up.data_in : hold_q;
        hold_full_d = accept || (hold_full_q && !load);
    end

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            busy_q      <= (state_d != ST_IDLE) || hold_full_d;
            in_ready_q  <= !hold_full_d;
            hold_full_q <= hold_full_d;
        end
    end

    // NOTE: payload and counters carry no reset; they are always written
    // before the control path that reads them can reach them.
    always_ff @(posedge clk_100m) begin
        hold_q  <= hold_d;
        shreg_q <= shreg_d;
        idx_q   <= idx_d;
        stop_q  <= stop_d;
        par_q   <= par_d;
    end

    assign up.in_ready = in_ready_q;
    assign tx          = tx_q;
    assign tx_busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench: four transmitter configurations against a frame-level
// reference model, plus hand-computed line sequences for each scenario.
module tb_uart_tx_param;
    import uart_pkg::*;

    localparam int CPB        = 4;
    localparam int N_DUT      = 4;
    localparam int WAIT_LIMIT = 400;
    // 0: 8E1, 1: 8O1, 2: 8N1, 3: 7N2
    localparam int DB  [N_DUT] = '{8, 8, 8, 7};
    localparam int PAR [N_DUT] = '{PARITY_EVEN, PARITY_ODD, PARITY_NONE, PARITY_NONE};
    localparam int SB  [N_DUT] = '{1, 1, 1, 2};

    logic             clk = 1'b0;
    logic             rst;
    logic [N_DUT-1:0] v;
    logic [8:0]       d [N_DUT];
    logic [N_DUT-1:0] tx_w, busy_w, rdy_w;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        uart_tx_param_if #(.DATA_BITS(DB[g])) bus ();
        assign bus.data_in  = d[g][DB[g]-1:0];
        assign bus.in_valid = v[g];
        assign rdy_w[g]     = bus.in_ready;

        uart_tx_param #(
            .DATA_BITS    (DB[g]),
            .PARITY       (PAR[g]),
            .STOP_BITS    (SB[g]),
            .CLKS_PER_BIT (CPB)
        ) u_dut (
            .clk_100m (clk),
            .rst      (rst),
            .up       (bus),
            .tx       (tx_w[g]),
            .tx_busy  (busy_w[g])
        );
    end

    // Reference model: a frame is a bit vector, the line shows bit pos/CPB.
    bit         m_act   [N_DUT];
    int         m_pos   [N_DUT];
    int         m_len   [N_DUT];
    logic [15:0] m_frame [N_DUT];
    bit         m_hfull [N_DUT];
    logic [8:0] m_hold  [N_DUT];

    function automatic int frame_bits(input int i);
        return 1 + DB[i] + ((PAR[i] != PARITY_NONE) ? 1 : 0) + SB[i];
    endfunction

    function automatic logic [15:0] frame_of(input int i, input logic [8:0] data);
        logic [15:0] f;
        int ones;
        f    = '1;
        ones = 0;
        f[0] = 1'b0;
        for (int k = 0; k < DB[i]; k++) begin
            f[1+k] = data[k];
            ones  += int'(data[k]);
        end
        if (PAR[i] == PARITY_ODD)       f[1+DB[i]] = (ones % 2 == 0);
        else if (PAR[i] == PARITY_EVEN) f[1+DB[i]] = (ones % 2 == 1);
        return f;
    endfunction

    function automatic logic exp_tx(input int i);
        return m_act[i] ? m_frame[i][m_pos[i]/CPB] : 1'b1;
    endfunction

    // Advances the model by one edge using the inputs that edge will sample.
    task automatic model_step();
        for (int i = 0; i < N_DUT; i++) begin
            if (rst) begin
                m_act[i]   = 1'b0;
                m_hfull[i] = 1'b0;
                m_pos[i]   = 0;
            end else begin
                bit ready_before;
                ready_before = !m_hfull[i];
                if (m_act[i]) begin
                    m_pos[i]++;
                    if (m_pos[i] == m_len[i]) m_act[i] = 1'b0;
                end
                if (!m_act[i] && m_hfull[i]) begin
                    m_frame[i] = frame_of(i, m_hold[i]);
                    m_len[i]   = frame_bits(i) * CPB;
                    m_pos[i]   = 0;
                    m_act[i]   = 1'b1;
                    m_hfull[i] = 1'b0;
                end
                if (v[i] && ready_before) begin
                    m_hold[i]  = d[i];
                    m_hfull[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < N_DUT; i++) begin
                    check($sformatf("tx%0d", i),       32'(tx_w[i]),   32'(exp_tx(i)));
                    check($sformatf("tx_busy%0d", i),  32'(busy_w[i]), 32'(m_act[i] || m_hfull[i]));
                    check($sformatf("in_ready%0d", i), 32'(rdy_w[i]),  32'(!m_hfull[i]));
                end
            end
            model_step();
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Offers a word and returns just after the accepting edge with valid still high.
    task automatic send(input int i, input logic [8:0] data);
        bit ok;
        ok   = 1'b0;
        d[i] = data;
        v[i] = 1'b1;
        for (int t = 0; t < WAIT_LIMIT && !ok; t++) begin
            @(negedge clk);
            ok = rdy_w[i];
        end
        check($sformatf("send_ready%0d", i), 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Records the line from the first start bit until tx_busy drops.
    task automatic watch(input int i, output logic [31:0] bits, output int len);
        bit seen;
        seen = 1'b0;
        bits = '1;
        len  = 0;
        for (int t = 0; t < WAIT_LIMIT && !seen; t++) begin
            @(negedge clk);
            seen = (tx_w[i] == 1'b0);
        end
        check($sformatf("watch_start%0d", i), 32'(seen), 32'd1);
        while (seen && busy_w[i] && len < 128) begin
            if (len % CPB == 1) bits[len/CPB] = tx_w[i];
            len++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] b0, b1, b2, b3;
        int          l0, l1, l2, l3;
        logic [8:0]  cap;
        bit          ok;
        int          lows;

        rst = 1'b1;
        v   = '0;
        for (int i = 0; i < N_DUT; i++) d[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N_DUT; i++) begin
            check($sformatf("reset_tx%0d", i),       32'(tx_w[i]),   32'd1);
            check($sformatf("reset_busy%0d", i),     32'(busy_w[i]), 32'd0);
            check($sformatf("reset_in_ready%0d", i), 32'(rdy_w[i]),  32'd1);
        end
        chk_en = 1'b1;

        // 8E1, 0xA5
        sync();
        fork
            watch(0, b0, l0);
            begin send(0, 9'h0A5); v[0] = 1'b0; end
        join
        check("s1_bits", 32'(b0[10:0]), 32'({1'b1, 1'b0, 8'hA5, 1'b0}));
        check("s1_len",  32'(l0), 32'd44);

        // 0x07 under even, odd and no parity
        sync();
        fork
            watch(0, b0, l0);
            watch(1, b1, l1);
            watch(2, b2, l2);
            begin send(0, 9'h007); v[0] = 1'b0; end
            begin send(1, 9'h007); v[1] = 1'b0; end
            begin send(2, 9'h007); v[2] = 1'b0; end
        join
        check("s2_even_par",  32'(b0[9]), 32'd1);
        check("s2_odd_par",   32'(b1[9]), 32'd0);
        check("s2_odd_bits",  32'(b1[10:0]), 32'({1'b1, 1'b0, 8'h07, 1'b0}));
        check("s2_odd_len",   32'(l1), 32'd44);
        check("s2_none_bits", 32'(b2[9:0]), 32'({1'b1, 8'h07, 1'b0}));
        check("s2_none_len",  32'(l2), 32'd40);

        // back-to-back 0x55, 0xAA, 8N1
        sync();
        fork
            watch(2, b2, l2);
            begin send(2, 9'h055); send(2, 9'h0AA); v[2] = 1'b0; end
        join
        check("s3_bits", 32'(b2[19:0]), 32'({1'b1, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0}));
        check("s3_len",  32'(l2), 32'd80);

        // 7N2, 0x41
        sync();
        fork
            watch(3, b3, l3);
            begin send(3, 9'h041); v[3] = 1'b0; end
        join
        check("s4_bits", 32'(b3[9:0]), 32'({1'b1, 1'b1, 7'h41, 1'b0}));
        check("s4_len",  32'(l3), 32'd40);

        // reset mid-frame with a word held
        sync();
        send(2, 9'h03C);
        send(2, 9'h0C3);
        v[2] = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("s5_tx",       32'(tx_w[2]),   32'd1);
        check("s5_in_ready", 32'(rdy_w[2]),  32'd1);
        check("s5_busy",     32'(busy_w[2]), 32'd0);
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (!tx_w[2] || busy_w[2]) lows++;
        end
        check("s5_no_restart", 32'(lows), 32'd0);

        // data_in churns while in_ready is low; only the accepted value is sent
        sync();
        cap = '0;
        ok  = 1'b0;
        fork
            watch(2, b2, l2);
            begin
                send(2, 9'h011);
                send(2, 9'h022);
                for (int t = 0; t < WAIT_LIMIT && !ok; t++) begin
                    d[2] = 9'(9'h080 + t);
                    @(negedge clk);
                    ok = rdy_w[2];
                    if (ok) cap = d[2];
                    @(posedge clk);
                    #1;
                end
                v[2] = 1'b0;
                d[2] = 9'h1FF;
            end
        join
        check("s6_accepted", 32'(ok), 32'd1);
        check("s6_bits2",    32'(b2[19:10]), 32'({1'b1, 8'h22, 1'b0}));
        check("s6_bits3",    32'(b2[29:20]), 32'({1'b1, cap[7:0], 1'b0}));
        check("s6_len",      32'(l2), 32'd120);

        repeat (5) sync();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter, the next-generation serial TX for the FPGA UART path. It generates its own bit timing from `clk_100m`, so no external `clken` is needed. Frame format is set at elaboration: data width, parity mode and stop-bit count. A valid/ready input with a one-entry holding register lets the upstream producer stream frames back-to-back with no idle gap on the line.

## Interface
- Parameters:
  - `DATA_BITS`, default 8: payload bits per frame, legal range 5..9.
  - `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
  - `STOP_BITS`, default 1: 1 or 2.
  - `CLKS_PER_BIT`, default 868: `clk_100m` cycles per bit (115200 baud at 100 MHz). Must be at least 2.
- Ports:
  - `clk_100m` input 1: the single clock.
  - `rst` input 1: synchronous, active-high reset.
  - `data_in` input `DATA_BITS`: payload, sent LSB first.
  - `in_valid` input 1: producer offers `data_in`.
  - `in_ready` output 1: holding register empty. A transfer occurs on any edge where `in_valid && in_ready`.
  - `tx` output 1: serial line, registered, idles high.
  - `tx_busy` output 1: high when the FSM is not IDLE or the holding register is full.

## Operation
- One clock and one reset: everything is on `clk_100m` with synchronous, active-high `rst`.
- Reset values: `tx`=1, `in_ready`=1, `tx_busy`=0, FSM=IDLE, holding register empty, baud counter=0.
- Holding register:
  - Loaded on a handshake.
  - `in_ready` is the registered value of `!hold_full`, so accept and drain never happen on the same edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE, hold full: copy hold into the shift register, clear hold, set `tx<=0`, restart the baud counter, go to START.
  - START: after one bit time, drive bit 0 and go to DATA.
  - DATA: each bit time shifts out the next bit. After bit `DATA_BITS-1`:
    - `PARITY` != 0: go to PARITY.
    - `PARITY` = 0: go to STOP.
  - PARITY: drive the parity bit for one bit time.
    - Odd parity: total number of ones across data and parity is odd.
    - Even parity: that total is even.
    - Parity is computed from the shift-register copy, never from `data_in`.
  - STOP: `tx`=1 for `STOP_BITS` bit times. At the end of the final stop bit:
    - Hold full: load it and set `tx<=0` on that same edge, going straight to START with zero idle cycles.
    - Hold empty: go to IDLE.
- Frame length: `(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT` cycles exactly.
- `data_in` changing after a handshake has no effect on the frame in flight.
- Reset mid-frame: the frame is aborted and the held word discarded. `tx`=1 on the edge after `rst` is sampled high.

## Timing
- A handshake at edge N gives hold full after N. If the FSM is IDLE, `tx` falls after edge N+1, a latency of 1 cycle. `in_ready` is low from N until N+1 and is high again after N+1.
- Each bit holds `tx` stable for exactly `CLKS_PER_BIT` cycles. The baud counter runs 0..`CLKS_PER_BIT-1` and wraps.
- The baud counter is restarted only at the start of a frame, so there is no phase carry-over from a previous frame.
- While a frame is in flight, at most one further word can be accepted. After that, `in_ready` stays low until that word is loaded at the frame boundary.
- `tx_busy` is registered and reflects state after each edge. It is low only when IDLE with hold empty.

## Structure
- Shared package `uart_pkg` contains:
  - The parity mode constants `PARITY_NONE`, `PARITY_ODD` and `PARITY_EVEN`.
  - The FSM state encoding for IDLE, START, DATA, PARITY and STOP.
  - `CLKS_PER_BIT_115200` = 868.
  - The elaboration-time legality checks on the parameters.
- One sub-module, `uart_baud_gen`:
  - Counter of width `$clog2(CLKS_PER_BIT)` with `restart` and `enable` inputs.
  - Outputs a one-cycle `bit_end` pulse.
  - Will be reused by the RX block.
- The bit index counter is `$clog2(DATA_BITS)` wide. The stop-bit counter is 1 bit wide.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
1. 8 bits, even parity, 1 stop bit. Send 0xA5. Required line sequence: 0 | 1,0,1,0,0,1,0,1 | 0 | 1, each bit 4 cycles, 44 cycles total. `tx_busy` falls on the cycle after the stop bit ends.
2. 8 bits, odd parity. Send 0x07: parity bit 0. With even parity, 0x07 gives parity bit 1. With no parity, 0x07 gives a 40-cycle frame with no parity slot.
3. Back-to-back: hold `in_valid` high with 0x55 then 0xAA. Required:
   - The 0xAA start bit begins on the cycle right after the 0x55 stop bit.
   - No idle-high gap; 80 cycles total with parity off.
   - `in_ready` low between the second accept and the frame-1/frame-2 boundary.
4. 7 bits, no parity, 2 stop bits. Send 0x41: 0 | 1,0,0,0,0,0,1 | 1,1, 40 cycles total.
5. Assert `rst` for 1 cycle at cycle 10 of a frame while a second word is held. Required:
   - `tx`=1, `in_ready`=1 and `tx_busy`=0 on the next cycle.
   - No further start bit; the held word is discarded.
6. Hold `in_valid` with `in_ready` low, changing `data_in` every cycle: only the value present at the `in_ready` edge is transmitted.
